synapse_feeder: RTL and testbench
=================================

SYNAPSE_FEEDER -- requirements
Module: synapse_feeder

Interface
REQ-001 Parameter N_SYN, default 8: number of synapses per neuron (2..64).
REQ-002 Parameter DATA_W, default 8: signed weight width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; begins one neuron evaluation.
REQ-006 spike_in  in  N_SYN  input spike vector; bit i set means synapse i fires.
REQ-007 wr_en  in  1  weight write strobe.
REQ-008 wr_addr  in  clog2(N_SYN)  weight index to write.
REQ-009 wr_data  in  DATA_W  signed weight value.
REQ-010 startAdd  in  1  adder controller accepted the offered addend this cycle.
REQ-011 sinAddFin  in  1  the accepted addend has been summed.
REQ-012 inReady  out  1  addend valid and offered.
REQ-013 lastAdd  out  1  no further addends this evaluation.
REQ-014 addend  out  DATA_W  signed weight of the current synapse.
REQ-015 busy  out  1  evaluation in progress (any state except IDLE and LAST).
REQ-016 n_added  out  clog2(N_SYN+1)  count of addends accepted this evaluation.

Function
REQ-017 FSM states: IDLE, SCAN, OFFER, WAIT, LAST.
REQ-018 IDLE: on start, latch spike_in, set idx=0, clear n_added, go to SCAN.
REQ-019 SCAN, spike bit idx set: load addend=weight[idx] and go to OFFER on the next cycle.
REQ-020 SCAN, spike bit idx clear: if idx==N_SYN-1 go to LAST, else increment idx and stay in SCAN. Each SCAN cycle tests one index.
REQ-021 OFFER: inReady=1 and addend is held stable. When startAdd=1, increment n_added and go to WAIT.
REQ-022 WAIT: inReady=0 and addend is held. When sinAddFin=1, go to LAST if idx==N_SYN-1, else increment idx and go to SCAN.
REQ-023 LAST: lastAdd=1 and inReady=0. Hold until the next start, which behaves as in IDLE and clears lastAdd on the following edge.
REQ-024 inReady and lastAdd are never high in the same cycle.
REQ-025 A start received while busy=1 is ignored.
REQ-026 A weight write is applied only while busy=0. A write while busy=1 is dropped.
REQ-027 A write and a start in the same cycle: the write completes first, so the new weight is visible to the evaluation.
REQ-028 startAdd while not in OFFER is ignored. sinAddFin while not in WAIT is ignored.
REQ-029 All-zero spike vector: lastAdd rises N_SYN cycles after start with n_added=0.
REQ-030 n_added saturates at N_SYN and never wraps.
REQ-031 Minimum latency per fired synapse: 1 SCAN cycle + 1 OFFER cycle + WAIT duration.

Reset
REQ-032 rst forces state IDLE, idx=0, n_added=0, inReady=0, lastAdd=0, addend=0, busy=0, and all weights to 0.
REQ-033 rst asserted mid-evaluation aborts it immediately. No addend is offered after rst deasserts until a new start.

Structure
REQ-034 A shared package holds the state encoding constants and the default N_SYN and DATA_W values.
REQ-035 One sub-module, synapse_weight_rf, implements the weight storage: N_SYN x DATA_W registers, one write port, one combinational read port.
REQ-036 Only the FSM, idx counter and n_added counter live in synapse_feeder.

Verification
REQ-037 Scenario 1 (single synapse). Weights w[i]=i+1, N_SYN=8, spike_in=8'b0000_0101, adder acking startAdd immediately and sinAddFin 2 cycles later. Required: addend sequence 1 then 3; lastAdd high; n_added=2.
REQ-038 Scenario 2 (empty vector). spike_in=0. Required: lastAdd rises exactly 8 cycles after start; inReady never high; n_added=0.
REQ-039 Scenario 3 (backpressure). spike_in=8'h80, w[7]=-5, startAdd withheld 4 cycles. Required: inReady held high with addend=-5 for all 4 cycles; exactly one acceptance; lastAdd follows sinAddFin.
REQ-040 Scenario 4 (write while busy). Write w[3]=9 during an evaluation with spike_in=8'h08 and old w[3]=2. Required: addend=2; readback after completion shows w[3]=2.
REQ-041 Scenario 5 (reset mid-operation). Assert rst while in WAIT. Required: all outputs 0 the same cycle; no inReady after release until a new start; weights read 0.
REQ-042 Scenario 6 (full vector with the adder FSM). spike_in=8'hFF, all weights 1, connected to the adder controller. Required: 8 adds; inReady and lastAdd never overlap; n_added=8.

Source files
------------

// File: rtl/synapse_feeder_pkg.sv
// Shared definitions for the synapse feeder: default sizing and FSM state encoding.
// Ports: none (package only).
// Imported by synapse_feeder and synapse_weight_rf.
package synapse_feeder_pkg;

  localparam int N_SYN_DEFAULT  = 8;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_OFFER = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LAST  = 3'd4
  } state_t;

endpackage

// File: rtl/synapse_weight_rf.sv
// Weight register file: N_SYN signed weights, one write port, one combinational read port.
// Ports: clk/rst, wr_en/wr_addr/wr_data (write, lands on rising edge), rd_addr -> rd_data (same cycle).
// No backpressure; the write is always taken, gating is the caller's job.
module synapse_weight_rf
  import synapse_feeder_pkg::*;
#(
  parameter int N_SYN  = N_SYN_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  localparam int AW    = $clog2(N_SYN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [N_SYN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SYN; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < N_SYN)) begin
      // Addresses past N_SYN (non power-of-two sizes) are dropped.
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synapse_feeder.sv
// Synapse feeder: walks the latched spike vector and offers the weight of each fired synapse to an adder.
// Ports: start/spike_in (begin evaluation), wr_* (weight write, idle only), startAdd/sinAddFin (adder handshake),
//        inReady/addend (offer), lastAdd (evaluation done), busy, n_added (accepted addends).
// Latency: 1 cycle per unfired synapse; 1 SCAN + 1 OFFER + WAIT per fired one. Offer held until startAdd.
module synapse_feeder
  import synapse_feeder_pkg::*;
#(
  parameter int N_SYN  = N_SYN_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  localparam int IW    = $clog2(N_SYN),
  localparam int CW    = $clog2(N_SYN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_SYN-1:0]         spike_in,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     startAdd,
  input  logic                     sinAddFin,
  output logic                     inReady,
  output logic                     lastAdd,
  output logic signed [DATA_W-1:0] addend,
  output logic                     busy,
  output logic [CW-1:0]            n_added
);

  localparam logic [IW-1:0] IDX_LAST = IW'(N_SYN - 1);
  localparam logic [CW-1:0] N_MAX    = CW'(N_SYN);

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            nadd_q, nadd_d;
  logic [N_SYN-1:0]         spikes_q, spikes_d;
  logic signed [DATA_W-1:0] addend_q, addend_d;
  logic signed [DATA_W-1:0] w_rd;

  // Writes only land while idle or parked in LAST; the start in the same
  // cycle reads the register file no earlier than the following SCAN, so
  // it sees the freshly written weight.
  synapse_weight_rf #(
    .N_SYN  (N_SYN),
    .DATA_W (DATA_W)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en & ~busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q),
    .rd_data (w_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      nadd_q   <= '0;
      spikes_q <= '0;
      addend_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nadd_q   <= nadd_d;
      spikes_q <= spikes_d;
      addend_q <= addend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nadd_d   = nadd_q;
    spikes_d = spikes_q;
    addend_d = addend_q;
    case (state_q)
      // LAST accepts a new start exactly like IDLE.
      ST_IDLE, ST_LAST: begin
        if (start) begin
          spikes_d = spike_in;
          idx_d    = '0;
          nadd_d   = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (spikes_q[idx_q]) begin
          addend_d = w_rd;
          state_d  = ST_OFFER;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_LAST;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_OFFER: begin
        if (startAdd) begin
          if (nadd_q != N_MAX) nadd_d = nadd_q + CW'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sinAddFin) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_LAST;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so inReady and
  // lastAdd are mutually exclusive by construction.
  assign inReady = (state_q == ST_OFFER);
  assign lastAdd = (state_q == ST_LAST);
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_LAST);
  assign addend  = addend_q;
  assign n_added = nadd_q;

endmodule

// File: tb/tb_synapse_feeder.sv
// Self-checking bench for synapse_feeder: reset values, a vector table, directed corner cases, random evaluations.
// Ports: none; drives the DUT and plays the adder controller.
// Expected results come from a weight array model and latency arithmetic.
module tb_synapse_feeder;

  localparam int N  = 8;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [N-1:0]         spike_in;
  logic                 wr_en;
  logic [2:0]           wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 startAdd;
  logic                 sinAddFin;
  logic                 inReady;
  logic                 lastAdd;
  logic signed [DW-1:0] addend;
  logic                 busy;
  logic [3:0]           n_added;

  synapse_feeder #(.N_SYN(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .spike_in  (spike_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .startAdd  (startAdd),
    .sinAddFin (sinAddFin),
    .inReady   (inReady),
    .lastAdd   (lastAdd),
    .addend    (addend),
    .busy      (busy),
    .n_added   (n_added)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int wmodel [N];
  int exp_q [$];
  int got_q [$];
  int last_lat;
  int last_sum;
  int offer_cycles;

  typedef struct {
    logic [7:0] sp;
    int         ack;
    int         fin;
    int         exp_n;
    int         exp_sum;
    int         exp_lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic write_w(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a[2:0];
    wr_data = d[7:0];
    @(negedge clk);
    wr_en = 1'b0;
    wmodel[a] = d;
  endtask

  // One evaluation with the bench acting as adder: startAdd after ack_dly
  // extra offer cycles, sinAddFin fin_dly cycles after acceptance.
  task automatic run_eval(input logic [7:0] sp, input int ack_dly, input int fin_dly,
                          input bit noise, input bit ws_en, input bit bw_en, input bit sb_en,
                          input int wa, input int wd, input string tag);
    int  cyc, ofr, j, hold_bad, overlap, busy_bad, lat, n_exp;
    bit  pend, done;
    int  expected;
    if (ws_en) wmodel[wa] = wd;
    exp_q.delete();
    for (int i = 0; i < N; i++) if (sp[i]) exp_q.push_back(wmodel[i]);
    n_exp = exp_q.size();
    got_q.delete();
    @(negedge clk);
    spike_in = sp;
    start    = 1'b1;
    if (ws_en) begin
      wr_en = 1'b1; wr_addr = wa[2:0]; wr_data = wd[7:0];
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    cyc = 0; ofr = 0; j = 0; pend = 0; done = 0;
    hold_bad = 0; overlap = 0; busy_bad = 0; lat = -1; offer_cycles = 0;
    while (cyc < 400 && !done) begin
      if (inReady && lastAdd) overlap++;
      if (lastAdd) begin
        done = 1;
        lat  = cyc;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        if (bw_en && cyc == 0) begin
          wr_en = 1'b1; wr_addr = wa[2:0]; wr_data = wd[7:0];
        end else begin
          wr_en = 1'b0;
        end
        if (sb_en && cyc == 2) begin
          start = 1'b1; spike_in = ~sp;
        end else begin
          start = 1'b0;
        end
        startAdd  = 1'b0;
        sinAddFin = 1'b0;
        if (pend) begin
          j++;
          if (j == fin_dly) begin
            sinAddFin = 1'b1;
            pend = 0;
          end
        end else if (inReady) begin
          offer_cycles++;
          if (got_q.size() < exp_q.size()) expected = exp_q[got_q.size()];
          else expected = 9999;
          if (int'(addend) != expected) hold_bad++;
          if (ofr == ack_dly) begin
            startAdd = 1'b1;
            got_q.push_back(int'(addend));
            ofr = 0; pend = 1; j = 0;
          end else begin
            ofr++;
          end
        end
        if (noise) begin
          if (!inReady) startAdd = 1'b1;
          if (!pend && !sinAddFin) sinAddFin = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    startAdd = 1'b0; sinAddFin = 1'b0; start = 1'b0; wr_en = 1'b0;
    if (!done) $display("FAIL %s timeout: lastAdd not seen within 400 cycles", tag);
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " latency"}, lat, N + n_exp * (ack_dly + 1 + fin_dly));
    chk({tag, " n_added"}, n_added, n_exp);
    chk({tag, " count"}, got_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < got_q.size(); i++)
      chk($sformatf("%s addend[%0d]", tag, i), got_q[i], exp_q[i]);
    chk({tag, " overlap"}, overlap, 0);
    chk({tag, " hold"}, hold_bad, 0);
    chk({tag, " busy_during"}, busy_bad, 0);
    chk({tag, " busy_at_last"}, busy, 0);
    last_lat = lat;
    last_sum = 0;
    foreach (got_q[i]) last_sum += got_q[i];
  endtask

  initial begin
    int nw, seen_rdy;
    tbl[0] = '{8'h05, 0, 2, 2, 4, 14};
    tbl[1] = '{8'h00, 0, 1, 0, 0, 8};
    tbl[2] = '{8'hFF, 0, 1, 8, 36, 24};
    tbl[3] = '{8'h80, 3, 1, 1, 8, 13};
    tbl[4] = '{8'h01, 1, 3, 1, 1, 13};
    tbl[5] = '{8'hA5, 2, 1, 4, 18, 24};

    rst = 1'b1; start = 1'b0; spike_in = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; startAdd = 1'b0; sinAddFin = 1'b0;
    for (int i = 0; i < N; i++) wmodel[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst inReady", inReady, 0);
    chk("rst lastAdd", lastAdd, 0);
    chk("rst addend", addend, 0);
    chk("rst busy", busy, 0);
    chk("rst n_added", n_added, 0);
    rst = 1'b0;

    // Vector table with w[i] = i+1
    for (int i = 0; i < N; i++) write_w(i, i + 1);
    for (int t = 0; t < 6; t++) begin
      run_eval(tbl[t].sp, tbl[t].ack, tbl[t].fin, 0, 0, 0, 0, 0, 0, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d exp_n", t), n_added, tbl[t].exp_n);
      chk($sformatf("tbl%0d exp_sum", t), last_sum, tbl[t].exp_sum);
      chk($sformatf("tbl%0d exp_lat", t), last_lat, tbl[t].exp_lat);
      chk($sformatf("tbl%0d lastAdd", t), lastAdd, 1);
    end

    // Backpressure: w[7] = -5, startAdd withheld 4 cycles
    write_w(7, -5);
    run_eval(8'h80, 4, 1, 0, 0, 0, 0, 0, 0, "bp");
    chk("bp offer_cycles", offer_cycles, 5);
    chk("bp accepted", got_q.size(), 1);

    // Write while busy is dropped; readback via another evaluation
    write_w(3, 2);
    run_eval(8'h08, 0, 1, 0, 0, 1, 0, 3, 9, "wbusy");
    run_eval(8'h08, 0, 1, 0, 0, 0, 0, 0, 0, "wbusy_rb");
    chk("wbusy_rb w3", last_sum, 2);

    // Write together with start is visible to that evaluation
    run_eval(8'h08, 0, 1, 0, 1, 0, 0, 3, 7, "wstart");
    chk("wstart w3", last_sum, 7);

    // Start while busy ignored; stray handshakes ignored
    run_eval(8'h81, 1, 1, 0, 0, 0, 1, 0, 0, "sbusy");
    run_eval(8'h5A, 1, 2, 1, 0, 0, 0, 0, 0, "noise");

    // Full vector, all weights 1
    for (int i = 0; i < N; i++) write_w(i, 1);
    run_eval(8'hFF, 0, 2, 0, 0, 0, 0, 0, 0, "full");
    chk("full sum", last_sum, 8);

    // Random evaluations
    for (int r = 0; r < 20; r++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) write_w($urandom_range(0, 7), int'($urandom_range(0, 255)) - 128);
      run_eval(8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(1, 3),
               1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, $sformatf("rnd%0d", r));
    end

    // Reset while in WAIT
    write_w(0, 7);
    @(negedge clk);
    spike_in = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid offer", inReady, 1);
    startAdd = 1'b1;
    @(negedge clk);
    startAdd = 1'b0;
    chk("mid wait busy", busy, 1);
    chk("mid wait n_added", n_added, 1);
    rst = 1'b1;
    #1;
    chk("mid rst inReady", inReady, 0);
    chk("mid rst lastAdd", lastAdd, 0);
    chk("mid rst addend", addend, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst n_added", n_added, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) wmodel[i] = 0;
    seen_rdy = 0;
    for (int c = 0; c < 12; c++) begin
      startAdd  = 1'b1;
      sinAddFin = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (inReady || lastAdd || busy) seen_rdy++;
    end
    startAdd = 1'b0; sinAddFin = 1'b0;
    chk("post rst idle", seen_rdy, 0);
    run_eval(8'hFF, 0, 1, 0, 0, 0, 0, 0, 0, "post_rst");
    chk("post_rst weights zero", last_sum, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
